// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: drives y to zero one micro-rotation per clock
// and returns the gain-scaled magnitude and an 8-bit binary angle (128 = pi).
module cordic_vectoring_iter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ITERS  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   x_in,
    input  logic [DATA_W-1:0]   y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W+1:0]   mag_out,
    output logic [7:0]          ang_out
);

    localparam int unsigned IW = DATA_W + 2;
    localparam int unsigned CW = 4;
    localparam int unsigned ZW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FOLD,
        S_ITER,
        S_DONE
    } state_t;

    state_t               state_q;
    logic signed [IW-1:0] x_q;
    logic signed [IW-1:0] y_q;
    logic [ZW-1:0]        z_q;
    logic [CW-1:0]        cnt_q;

    logic signed [IW-1:0] x_sh_c;
    logic signed [IW-1:0] y_sh_c;
    logic [ZW-1:0]        atan_c;

    // round(atan(2^-i) * 128 / pi)
    function automatic logic [ZW-1:0] atan_lut(input logic [CW-1:0] idx);
        case (idx)
            4'd0:    atan_lut = 8'd32;
            4'd1:    atan_lut = 8'd19;
            4'd2:    atan_lut = 8'd10;
            4'd3:    atan_lut = 8'd5;
            4'd4:    atan_lut = 8'd3;
            4'd5:    atan_lut = 8'd1;
            4'd6:    atan_lut = 8'd1;
            default: atan_lut = 8'd0;
        endcase
    endfunction

    assign x_sh_c = x_q >>> cnt_q;
    assign y_sh_c = y_q >>> cnt_q;
    assign atan_c = atan_lut(cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mag_out   <= '0;
            ang_out   <= '0;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        x_q      <= IW'($signed(x_in));
                        y_q      <= IW'($signed(y_in));
                        z_q      <= '0;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    // Rotate left-half-plane vectors by +/-90 deg so the iterations converge
                    if (x_q[IW-1]) begin
                        if (!y_q[IW-1]) begin
                            x_q <= y_q;
                            y_q <= -x_q;
                            z_q <= 8'd64;
                        end else begin
                            x_q <= -y_q;
                            y_q <= x_q;
                            z_q <= 8'd192;
                        end
                    end
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    if (cnt_q == CW'(ITERS)) begin
                        mag_out   <= $unsigned(x_q);
                        ang_out   <= z_q;
                        out_valid <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        if (!y_q[IW-1]) begin
                            x_q <= x_q + y_sh_c;
                            y_q <= y_q - x_sh_c;
                            z_q <= z_q + atan_c;
                        end else begin
                            x_q <= x_q - y_sh_c;
                            y_q <= y_q + x_sh_c;
                            z_q <= z_q - atan_c;
                        end
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Bench for cordic_vectoring_iter: vector table with spec ranges, integer golden
// model feeding a result scoreboard, plus backpressure and mid-operation reset.
module tb_cordic_vectoring_iter;

    localparam int DATA_W = 8;
    localparam int ITERS  = 7;
    localparam int LAT    = ITERS + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x_in;
    logic [DATA_W-1:0] y_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W+1:0] mag_out;
    logic [7:0]        ang_out;

    cordic_vectoring_iter #(.DATA_W(DATA_W), .ITERS(ITERS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .ang_out   (ang_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        int ang;
        bit skip_ang;
    } exp_t;

    typedef struct {
        int x;
        int y;
        int mag_lo;
        int mag_hi;
        int ang_c;
        int ang_tol;
        bit chk_ang;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int atan_ref(input int i);
        case (i)
            0: return 32;
            1: return 19;
            2: return 10;
            3: return 5;
            4: return 3;
            5: return 1;
            6: return 1;
            default: return 0;
        endcase
    endfunction

    // Integer reference of the fold + micro-rotation sequence
    function automatic void model(input int xi, input int yi, output int mag, output int ang);
        int x, y, z, xn, yn;
        x = xi; y = yi; z = 0;
        if (x < 0) begin
            if (y >= 0) begin xn = y;  yn = -x; z = 64;  end
            else        begin xn = -y; yn = x;  z = -64; end
            x = xn; y = yn;
        end
        for (int i = 0; i < ITERS; i++) begin
            if (y >= 0) begin xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_ref(i); end
            else        begin xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_ref(i); end
            x = xn; y = yn;
        end
        mag = x;
        ang = z & 255;
    endfunction

    function automatic int adiff(input logic [7:0] a, input int c);
        logic [7:0] d;
        d = a - 8'(c);
        return int'($signed(d));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int xi, input int yi, input bit skip_ang);
        exp_t e;
        model(xi, yi, e.mag, e.ang);
        e.skip_ang = skip_ang;
        sb.push_back(e);
    endtask

    task automatic start_op(input int xi, input int yi, input bit skip_ang);
        int n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        if (!in_ready) begin
            chk("in_ready_timeout", int'(in_ready), 1);
            return;
        end
        x_in = 8'(xi);
        y_in = 8'(yi);
        in_valid = 1'b1;
        push_exp(xi, yi, skip_ang);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        if (!out_valid) chk("out_valid_timeout", int'(out_valid), 1);
    endtask

    // Scoreboard: compare each result as it is consumed
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", int'(mag_out), -1);
            end else begin
                e = sb.pop_front();
                chk("sb_mag", int'(mag_out), e.mag);
                if (!e.skip_ang) chk("sb_ang", int'(ang_out), e.ang);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int lat;
        int m0, a0;
        string nm;

        tbl[0] = '{x: 100,  y: 0,    mag_lo: 166, mag_hi: 166, ang_c: 1,   ang_tol: 0, chk_ang: 1'b1};
        tbl[1] = '{x: 0,    y: 100,  mag_lo: 164, mag_hi: 166, ang_c: 64,  ang_tol: 2, chk_ang: 1'b1};
        tbl[2] = '{x: 0,    y: -100, mag_lo: 164, mag_hi: 167, ang_c: -64, ang_tol: 2, chk_ang: 1'b1};
        tbl[3] = '{x: -128, y: 0,    mag_lo: 209, mag_hi: 214, ang_c: 128, ang_tol: 2, chk_ang: 1'b1};
        tbl[4] = '{x: -128, y: -128, mag_lo: 296, mag_hi: 300, ang_c: -96, ang_tol: 2, chk_ang: 1'b1};
        tbl[5] = '{x: 127,  y: 127,  mag_lo: 294, mag_hi: 298, ang_c: 32,  ang_tol: 2, chk_ang: 1'b1};
        tbl[6] = '{x: 0,    y: 0,    mag_lo: 0,   mag_hi: 0,   ang_c: 0,   ang_tol: 0, chk_ang: 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x_in = '0;
        y_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_mag", int'(mag_out), 0);
        chk("rst_ang", int'(ang_out), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start_op(tbl[i].x, tbl[i].y, !tbl[i].chk_ang);
            wait_valid(lat);
            nm = $sformatf("v%0d", i);
            chk({nm, "_latency"}, lat, LAT);
            chk_rng({nm, "_mag_range"}, int'(mag_out), tbl[i].mag_lo, tbl[i].mag_hi);
            if (tbl[i].chk_ang)
                chk_rng({nm, "_ang_range"}, adiff(ang_out, tbl[i].ang_c), -tbl[i].ang_tol, tbl[i].ang_tol);
            tick();
        end

        // Backpressure with a second operand waiting on the input
        out_ready = 1'b0;
        start_op(37, -90, 1'b0);
        x_in = 8'(-60);
        y_in = 8'(45);
        in_valid = 1'b1;
        wait_valid(lat);
        m0 = int'(mag_out);
        a0 = int'(ang_out);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_mag_stable", int'(mag_out), m0);
            chk("bp_ang_stable", int'(ang_out), a0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("drain_in_ready", int'(in_ready), 1);
        chk("drain_out_valid", int'(out_valid), 0);
        push_exp(-60, 45, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("second_accepted", int'(in_ready), 0);
        wait_valid(lat);
        tick();

        // Reset while the step-3 micro-rotation is pending
        start_op(-77, 23, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_mag", int'(mag_out), 0);
        chk("mid_rst_ang", int'(ang_out), 0);
        sb.delete();
        #2;
        rst = 1'b0;
        start_op(90, -33, 1'b0);
        wait_valid(lat);
        chk("post_rst_latency", lat, LAT);
        tick();

        // Random operands with random consumer stalls
        for (int r = 0; r < 12; r++) begin
            int xr, yr;
            xr = int'($urandom_range(255)) - 128;
            yr = int'($urandom_range(255)) - 128;
            out_ready = 1'b0;
            start_op(xr, yr, (xr == 0 && yr == 0));
            wait_valid(lat);
            repeat ($urandom_range(3)) tick();
            out_ready = 1'b1;
            tick();
        end

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
